// File: rtl/seq_divider.sv
`default_nettype none
// =============================================================================
// Module      : seq_divider
// Description : Iterative restoring shift/subtract divider, one quotient bit
//               per cycle MSB first, with start/done handshake.
//               Define DIVIDER_SIGNED_EN for two's-complement operands.
// Revision    : 1.0 - initial release
// =============================================================================
module seq_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dvz
);

    localparam logic [1:0]       c_idle    = 2'd0;
    localparam logic [1:0]       c_run     = 2'd1;
    localparam logic [1:0]       c_fin     = 2'd2;
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ones    = '1;

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_r, w_r_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_quot, w_quot_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic             r_dvz, w_dvz_nxt;

    logic             w_accept;
    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_d;
    logic [WIDTH-1:0] w_r_step;
    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_dd_mag;
    logic [WIDTH-1:0] w_dv_mag;
    logic [WIDTH-1:0] w_quot_fin;
    logic [WIDTH-1:0] w_rem_fin;

    assign w_accept = start & ~r_busy;

    // One restoring step: the borrow bit of the (WIDTH+1)-bit difference decides the quotient bit
    assign w_rs     = {r_r, r_q[WIDTH-1]};
    assign w_d      = w_rs - {1'b0, r_dvs};
    assign w_r_step = w_d[WIDTH] ? w_rs[WIDTH-1:0] : w_d[WIDTH-1:0];
    assign w_q_step = {r_q[WIDTH-2:0], ~w_d[WIDTH]};

`ifdef DIVIDER_SIGNED_EN
    logic r_qneg;
    logic r_rneg;

    assign w_dd_mag   = dividend[WIDTH-1] ? (~dividend + c_one) : dividend;
    assign w_dv_mag   = divisor[WIDTH-1]  ? (~divisor + c_one)  : divisor;
    assign w_quot_fin = r_qneg ? (~w_q_step + c_one) : w_q_step;
    assign w_rem_fin  = r_rneg ? (~w_r_step + c_one) : w_r_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (w_accept) begin
            r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_rneg <= dividend[WIDTH-1];
        end
    end
`else
    assign w_dd_mag   = dividend;
    assign w_dv_mag   = divisor;
    assign w_quot_fin = w_q_step;
    assign w_rem_fin  = w_r_step;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_r_nxt     = r_r;
        w_q_nxt     = r_q;
        w_dvs_nxt   = r_dvs;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dvz_nxt   = r_dvz;

        case (r_state)
            c_run: begin
                w_r_nxt   = w_r_step;
                w_q_nxt   = w_q_step;
                w_cnt_nxt = r_cnt + c_cnt_one;
                if (r_cnt == c_last) begin
                    w_state_nxt = c_fin;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_quot_nxt  = w_quot_fin;
                    w_rem_nxt   = w_rem_fin;
                    w_dvz_nxt   = 1'b0;
                end
            end
            c_fin: begin
                // Still busy here only on the divide-by-zero path; r_q holds the raw dividend
                w_state_nxt = c_idle;
                if (r_busy) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_quot_nxt = c_ones;
                    w_rem_nxt  = r_q;
                    w_dvz_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = c_idle;
        endcase

        if (w_accept) begin
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = '0;
            w_r_nxt    = '0;
            w_dvs_nxt  = w_dv_mag;
            if (divisor == '0) begin
                w_state_nxt = c_fin;
                w_q_nxt     = dividend;
            end else begin
                w_state_nxt = c_run;
                w_q_nxt     = w_dd_mag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_dvs   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dvz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_r     <= w_r_nxt;
            r_q     <= w_q_nxt;
            r_dvs   <= w_dvs_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dvz   <= w_dvz_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quot = r_quot;
    assign rem  = r_rem;
    assign dvz  = r_dvz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// =============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider; directed cases plus random
//               operands against an arithmetic reference (DIVIDER_SIGNED_EN aware).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dvz;

    int n_checks = 0;
    int n_err    = 0;

    seq_divider #(.WIDTH(W), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .dvz      (dvz)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain language-level division, truncating toward zero in the signed build
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
`ifdef DIVIDER_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    // Called at a negedge with busy low; returns at the negedge of the done cycle
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           lat;
        ref_div(a, b, eq, er, ez);
        lat      = (b == '0) ? 2 : W + 1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        for (int k = 1; k < lat; k++) begin
            chk_b({tag, ".busy"}, busy, 1'b1);
            chk_b({tag, ".early_done"}, done, 1'b0);
            if (k == 1) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk_b({tag, ".done"}, done, 1'b1);
        chk_b({tag, ".busy_at_done"}, busy, 1'b0);
        chk_w({tag, ".quot"}, quot, eq);
        chk_w({tag, ".rem"}, rem, er);
        chk_b({tag, ".dvz"}, dvz, ez);
    endtask

    task automatic idle_step(input string tag, input logic [W-1:0] hq, input logic [W-1:0] hr);
        @(negedge clk);
        chk_b({tag, ".done_pulse"}, done, 1'b0);
        chk_w({tag, ".quot_hold"}, quot, hq);
        chk_w({tag, ".rem_hold"}, rem, hr);
    endtask

    initial begin
        logic         seen_done;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_b("reset.busy", busy, 1'b0);
        chk_b("reset.done", done, 1'b0);
        chk_w("reset.quot", quot, '0);
        chk_w("reset.rem", rem, '0);
        chk_b("reset.dvz", dvz, 1'b0);

        run_div(W'(100), W'(7), "d100_7");
        chk_w("d100_7.quot_const", quot, W'(14));
        chk_w("d100_7.rem_const", rem, W'(2));
        idle_step("d100_7", W'(14), W'(2));

        run_div(16'hFFFF, 16'h0001, "b2b_a");
        chk_w("b2b_a.quot_const", quot, 16'hFFFF);
        chk_w("b2b_a.rem_const", rem, 16'h0000);
        run_div(16'h0005, 16'h000A, "b2b_b");
        chk_w("b2b_b.quot_const", quot, 16'h0000);
        chk_w("b2b_b.rem_const", rem, 16'h0005);
        idle_step("b2b_b", 16'h0000, 16'h0005);

        run_div(W'(1234), W'(0), "dvz");
        chk_w("dvz.quot_const", quot, 16'hFFFF);
        chk_w("dvz.rem_const", rem, W'(1234));
        chk_b("dvz.flag_const", dvz, 1'b1);
        idle_step("dvz", 16'hFFFF, W'(1234));

        start    = 1'b1;
        dividend = W'(500);
        divisor  = W'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_b("rst_mid.busy", busy, 1'b0);
        chk_b("rst_mid.done", done, 1'b0);
        chk_w("rst_mid.quot", quot, '0);
        chk_w("rst_mid.rem", rem, '0);
        chk_b("rst_mid.dvz", dvz, 1'b0);
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk_b("rst_mid.no_done", seen_done, 1'b0);
        run_div(W'(9), W'(3), "after_rst");
        chk_w("after_rst.quot_const", quot, W'(3));
        chk_w("after_rst.rem_const", rem, W'(0));
        idle_step("after_rst", W'(3), W'(0));

`ifdef DIVIDER_SIGNED_EN
        run_div(16'hFFF9, 16'h0002, "s_m7_2");
        chk_w("s_m7_2.quot_const", quot, 16'hFFFD);
        chk_w("s_m7_2.rem_const", rem, 16'hFFFF);
        run_div(16'h0007, 16'hFFFE, "s_7_m2");
        chk_w("s_7_m2.quot_const", quot, 16'hFFFD);
        chk_w("s_7_m2.rem_const", rem, 16'h0001);
        run_div(16'h8000, 16'hFFFF, "s_ovf");
        chk_w("s_ovf.quot_const", quot, 16'h8000);
        chk_w("s_ovf.rem_const", rem, 16'h0000);
        chk_b("s_ovf.dvz_const", dvz, 1'b0);
        idle_step("s_ovf", 16'h8000, 16'h0000);
`endif

        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 16'hFFFF;
                3:       begin b = W'($urandom); a = W'($urandom_range(0, 3)); end
                default: b = W'($urandom);
            endcase
            run_div(a, b, "rand");
            if ($urandom_range(0, 1) == 0) begin
                ref_div(a, b, eq, er, ez);
                idle_step("rand", eq, er);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
